gf2_deconv_seq: RTL and testbench

// - Sequential GF(2) deconvolver: recovers x from y = x (*) h, where (*) is the carry-less (XOR-sum)

---
 rtl/gf2_deconv_seq_if.sv | 29 ++
 rtl/gf2_deconv_seq.sv | 148 ++++++++++++++
 tb/tb_gf2_deconv_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gf2_deconv_seq_if.sv
// Handshake bundle for gf2_deconv_seq: job request (y, h) and result.
// slave = the divider; master = the producer/consumer driving it.
interface gf2_deconv_seq_if #(
    parameter int X_W = 4,
    parameter int H_W = 4
);
    localparam int Y_W = X_W + H_W;

    logic           in_valid;
    logic           in_ready;
    logic [Y_W-1:0] y_in;
    logic [H_W-1:0] h_in;
    logic           out_valid;
    logic           out_ready;
    logic [X_W-1:0] x_out;
    logic [H_W-2:0] rem_out;
    logic           ovf;
    logic           div_err;

    modport slave (
        input  in_valid, y_in, h_in, out_ready,
        output in_ready, out_valid, x_out, rem_out, ovf, div_err
    );

    modport master (
        output in_valid, y_in, h_in, out_ready,
        input  in_ready, out_valid, x_out, rem_out, ovf, div_err
    );
endinterface

// File: rtl/gf2_deconv_seq.sv
// Bit-serial GF(2) polynomial divider: x = y / h, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), bus (gf2_deconv_seq_if.slave):
//   in_valid/in_ready/y_in/h_in request, out_valid/out_ready/x_out/rem_out/ovf/div_err result.
// Option: GF2_DECONV_EARLY_EXIT_EN ends the division as soon as the remainder is zero.
module gf2_deconv_seq #(
    parameter int X_W = 4,
    parameter int H_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    gf2_deconv_seq_if.slave    bus
);
    localparam int Y_W = X_W + H_W;
    localparam int IW  = $clog2(Y_W);
    localparam int DW  = $clog2(H_W);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t         state;
    logic [Y_W-1:0] rem;
    logic [Y_W-1:0] q;
    logic [H_W-1:0] hreg;
    logic [DW-1:0]  d;
    logic [IW-1:0]  i;

    logic           in_ready_r;
    logic           out_valid_r;
    logic [X_W-1:0] x_r;
    logic [H_W-2:0] rem_r;
    logic           ovf_r;
    logic           err_r;

    logic [DW-1:0]  d_in;
    logic [IW-1:0]  top;
    logic [Y_W-1:0] hsh;
    logic [Y_W-1:0] rem_nx;
    logic [Y_W-1:0] q_nx;
    logic           last;

    // Degree of the incoming divisor: index of its highest set bit.
    always_comb begin
        d_in = '0;
        for (int k = 0; k < H_W; k++) begin
            if (bus.h_in[k]) d_in = DW'(k);
        end
    end

    // One long-division step: top is the coefficient aligned with h's leading term.
    always_comb begin
        top    = i + IW'(d);
        hsh    = Y_W'(hreg) << i;
        rem_nx = rem;
        q_nx   = q;
        if (rem[top]) begin
            rem_nx  = rem ^ hsh;
            q_nx[i] = 1'b1;
        end
`ifdef GF2_DECONV_EARLY_EXIT_EN
        last = (i == '0) || (rem_nx == '0);
`else
        last = (i == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            x_r         <= '0;
            rem_r       <= '0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
            rem         <= '0;
            q           <= '0;
            hreg        <= '0;
            d           <= '0;
            i           <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        rem  <= bus.y_in;
                        q    <= '0;
                        hreg <= bus.h_in;
                        d    <= d_in;
                        i    <= IW'(Y_W - 1) - IW'(d_in);
                        in_ready_r <= 1'b0;
                        if (bus.h_in == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            x_r         <= '0;
                            rem_r       <= '0;
                            ovf_r       <= 1'b0;
                            err_r       <= 1'b1;
                        end
`ifdef GF2_DECONV_EARLY_EXIT_EN
                        else if (bus.y_in == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            x_r         <= '0;
                            rem_r       <= '0;
                            ovf_r       <= 1'b0;
                            err_r       <= 1'b0;
                        end
`endif
                        else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    q   <= q_nx;
                    i   <= i - 1'b1;
                    if (last) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        x_r         <= q_nx[X_W-1:0];
                        // Bits at or above deg(h) are cleared by the division.
                        rem_r       <= rem_nx[H_W-2:0];
                        ovf_r       <= |q_nx[Y_W-1:X_W];
                        err_r       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.x_out     = x_r;
    assign bus.rem_out   = rem_r;
    assign bus.ovf       = ovf_r;
    assign bus.div_err   = err_r;
endmodule

// File: tb/tb_gf2_deconv_seq.sv
// Testbench for gf2_deconv_seq: directed and random jobs against a
// reference that finds the quotient by searching carry-less products.
module tb_gf2_deconv_seq;
    localparam int X_W = 4;
    localparam int H_W = 4;
    localparam int Y_W = X_W + H_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    gf2_deconv_seq_if #(.X_W(X_W), .H_W(H_W)) bus ();

    gf2_deconv_seq #(.X_W(X_W), .H_W(H_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] clmul(input logic [7:0] a, input logic [3:0] b);
        logic [15:0] p;
        p = '0;
        for (int k = 0; k < 8; k++)
            if (a[k]) p = p ^ (16'(b) << k);
        return p;
    endfunction

    function automatic int deg(input logic [3:0] h);
        int d;
        d = 0;
        for (int k = 0; k < 4; k++)
            if (h[k]) d = k;
        return d;
    endfunction

    // q is the unique polynomial with deg(q*h ^ y) < deg(h).
    function automatic void model(input logic [7:0] y, input logic [3:0] h,
                                  output logic [7:0] q, output logic [7:0] r);
        logic [15:0] t;
        int d;
        q = '0;
        r = '0;
        if (h == '0) return;
        d = deg(h);
        for (int c = 0; c < 256; c++) begin
            t = clmul(8'(c), h) ^ {8'h00, y};
            if (t < (16'd1 << d)) begin
                q = 8'(c);
                r = t[7:0];
                return;
            end
        end
    endfunction

    task automatic chk_res(input string pfx, input logic [3:0] ex, input logic [2:0] er,
                           input logic eo, input logic ee);
        chk({pfx, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({pfx, "_x"}, 32'(bus.x_out), 32'(ex));
        chk({pfx, "_rem"}, 32'(bus.rem_out), 32'(er));
        chk({pfx, "_ovf"}, 32'(bus.ovf), 32'(eo));
        chk({pfx, "_err"}, 32'(bus.div_err), 32'(ee));
    endtask

    task automatic job(input logic [7:0] y, input logic [3:0] h, input int hold);
        logic [7:0] q;
        logic [7:0] r;
        logic [3:0] ex;
        logic [2:0] er;
        logic eo;
        logic ee;
        int n;
        int cyc;
        model(y, h, q, r);
        ex = q[3:0];
        er = r[2:0];
        eo = |q[7:4];
        ee = (h == '0);
        n  = (h == '0) ? 0 : Y_W - deg(h);
        chk("idle_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.y_in     = y;
        bus.h_in     = h;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.y_in     = 8'($urandom);
        bus.h_in     = 4'($urandom);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            bus.in_valid = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("no_timeout", 32'(cyc < 40), 32'd1);
`ifdef GF2_DECONV_EARLY_EXIT_EN
        chk("latency_bound", 32'(cyc <= n), 32'd1);
`else
        chk("latency", 32'(cyc), 32'(n));
`endif
        chk_res("res", ex, er, eo, ee);
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'b1;
            bus.y_in     = 8'($urandom);
            bus.h_in     = 4'($urandom);
            @(posedge clk); #1;
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
            chk_res("hold", ex, er, eo, ee);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("rel_valid", 32'(bus.out_valid), 32'd0);
        chk("rel_ready", 32'(bus.in_ready), 32'd1);
        chk("rel_x_kept", 32'(bus.x_out), 32'(ex));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.y_in      = '0;
        bus.h_in      = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_x", 32'(bus.x_out), 32'd0);
        chk("rst_rem", 32'(bus.rem_out), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_err", 32'(bus.div_err), 32'd0);

        job(8'h1D, 4'h3, 0);
        chk("d1_x_const", 32'(bus.x_out), 32'hB);
        job(8'h1E, 4'h3, 1);
        job(8'h1F, 4'h3, 0);
        chk("d3_rem_const", 32'(bus.rem_out), 32'h1);
        job(8'h80, 4'h1, 0);
        chk("d4_ovf_const", 32'(bus.ovf), 32'd1);
        job(8'h55, 4'h0, 0);
        chk("d5_err_const", 32'(bus.div_err), 32'd1);
        job(8'hF3, 4'hB, 5);
        job(8'h00, 4'h9, 0);
        job(8'hFF, 4'h8, 2);

        // Reset while dividing: next cycle back to reset values.
        bus.in_valid = 1'b1;
        bus.y_in     = 8'h1D;
        bus.h_in     = 4'h3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_x", 32'(bus.x_out), 32'd0);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        chk("mid_rst_err", 32'(bus.div_err), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_quiet", 32'(bus.out_valid), 32'd0);

        for (int t = 0; t < 30; t++) begin
            logic [7:0] ry;
            logic [3:0] rh;
            ry = 8'($urandom);
            rh = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            job(ry, rh, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
